// File: rtl/motion_control_peripheral.sv
// Memory-mapped motion-control peripheral: software loads four operand pairs,
// writes start, and an FSM produces per-pair direction codes and magnitudes.
//
// state  | meaning
// IDLE   | waiting for a start write
// SNAP   | copy operands into shadow registers
// CALC_V | vertical pair (RV1,RV2)
// CALC_H | horizontal pair (RH1,RH2)
// CALC_T | tilt pair (theta_m,theta_a)
// CALC_P | pan pair (phi_m,phi_a)
// DONE   | drop busy, raise done
module motion_control_peripheral #(
    parameter int DW       = 16,
    parameter int DEADBAND = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] d_in,
    input  logic          cs,
    input  logic [3:0]    addr,
    input  logic          rd,
    input  logic          wr,
    output logic [DW-1:0] d_out
);

    typedef enum logic [2:0] {
        IDLE, SNAP, CALC_V, CALC_H, CALC_T, CALC_P, DONE
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0] rv1, rv2, rh1, rh2, theta_m, theta_a, phi_m, phi_a;
    logic [DW-1:0] s_rv1, s_rv2, s_rh1, s_rh2, s_theta_m, s_theta_a, s_phi_m, s_phi_a;
    logic [DW-1:0] mag_v, mag_h, mag_t, mag_p;
    logic [7:0]    cmd;
    logic          busy, done;

    logic          wr_en, rd_en, start_ok;
    logic [DW-1:0] op_a, op_b, diff, rd_val;
    logic [1:0]    code;

    assign wr_en    = cs & wr;
    assign rd_en    = cs & rd;
    assign start_ok = (state == IDLE) && wr_en && (addr == 4'h0) && d_in[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = SNAP;
            SNAP:    state_nxt = CALC_V;
            CALC_V:  state_nxt = CALC_H;
            CALC_H:  state_nxt = CALC_T;
            CALC_T:  state_nxt = CALC_P;
            CALC_P:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv1     <= '0;
            rv2     <= '0;
            rh1     <= '0;
            rh2     <= '0;
            theta_m <= '0;
            theta_a <= '0;
            phi_m   <= '0;
            phi_a   <= '0;
        end else if (wr_en) begin
            case (addr)
                4'h1: phi_a   <= d_in;
                4'h2: rv1     <= d_in;
                4'h4: rv2     <= d_in;
                4'h6: rh1     <= d_in;
                4'h8: rh2     <= d_in;
                4'hA: theta_m <= d_in;
                4'hC: theta_a <= d_in;
                4'hE: phi_m   <= d_in;
                default: ;
            endcase
        end
    end

    // One shared comparator; the active CALC state picks which shadow pair feeds it.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state)
            CALC_V: begin op_a = s_rv1;     op_b = s_rv2;     end
            CALC_H: begin op_a = s_rh1;     op_b = s_rh2;     end
            CALC_T: begin op_a = s_theta_m; op_b = s_theta_a; end
            CALC_P: begin op_a = s_phi_m;   op_b = s_phi_a;   end
            default: ;
        endcase
    end

    always_comb begin
        diff = (op_a > op_b) ? (op_a - op_b) : (op_b - op_a);
        code = 2'b00;
        if (diff > DW'(DEADBAND)) code = (op_a > op_b) ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_rv1 <= '0; s_rv2 <= '0; s_rh1 <= '0; s_rh2 <= '0;
            s_theta_m <= '0; s_theta_a <= '0; s_phi_m <= '0; s_phi_a <= '0;
            mag_v <= '0; mag_h <= '0; mag_t <= '0; mag_p <= '0;
            cmd   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            if (start_ok) begin
                busy <= 1'b1;
                done <= 1'b0;
            end else if (state == DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            case (state)
                SNAP: begin
                    s_rv1 <= rv1; s_rv2 <= rv2; s_rh1 <= rh1; s_rh2 <= rh2;
                    s_theta_m <= theta_m; s_theta_a <= theta_a;
                    s_phi_m <= phi_m; s_phi_a <= phi_a;
                end
                CALC_V: begin mag_v <= diff; cmd[1:0] <= code; end
                CALC_H: begin mag_h <= diff; cmd[3:2] <= code; end
                CALC_T: begin mag_t <= diff; cmd[5:4] <= code; end
                CALC_P: begin mag_p <= diff; cmd[7:6] <= code; end
                default: ;
            endcase
        end
    end

    // Read mux sees pre-edge values, so a same-cycle write is not visible yet.
    always_comb begin
        rd_val = '0;
        case (addr)
            4'h0: rd_val = {{(DW-2){1'b0}}, done, busy};
            4'h1: rd_val = phi_a;
            4'h2: rd_val = rv1;
            4'h3: rd_val = {{(DW-8){1'b0}}, cmd};
            4'h4: rd_val = rv2;
            4'h5: rd_val = mag_v;
            4'h6: rd_val = rh1;
            4'h7: rd_val = mag_h;
            4'h8: rd_val = rh2;
            4'h9: rd_val = mag_t;
            4'hA: rd_val = theta_m;
            4'hB: rd_val = mag_p;
            4'hC: rd_val = theta_a;
            4'hE: rd_val = phi_m;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        d_out <= '0;
        else if (rd_en) d_out <= rd_val;
        else            d_out <= '0;
    end

endmodule

// File: tb/tb_motion_control_peripheral.sv
// Bench for motion_control_peripheral: expected read data is queued when a read
// strobe is issued and popped when d_out becomes valid one cycle later.
module tb_motion_control_peripheral;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] d_in = '0;
    logic        cs = 1'b0;
    logic [3:0]  addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] d_out;

    typedef struct {
        logic [3:0]  a;
        logic [15:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t ex;
    int   n_cmp = 0;
    int   n_bad = 0;

    motion_control_peripheral #(.DW(16), .DEADBAND(2)) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr),
        .rd(rd), .wr(wr), .d_out(d_out)
    );

    always #5 clk = ~clk;

    task automatic wr_cycle(input logic [3:0] a, input logic [15:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0; d_in = '0;
    endtask

    task automatic rd_cycle(input logic [3:0] a, input logic [15:0] e);
        exp_t t;
        t.a = a; t.v = e;
        sb.push_back(t);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(posedge clk); #1;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; cs = 1'b1; wr = 1'b1; d_in = 16'h0000; addr = 4'h0;
        idle(4);
        n_cmp++;
        if (d_out !== 16'h0000) begin
            n_bad++; $display("FAIL reset_dout got %h want %h", d_out, 16'h0000);
        end
        rst = 1'b0; cs = 1'b0; wr = 1'b0;
        idle(1);
        rd_cycle(4'h0, 16'h0000);
        ex = sb.pop_front(); n_cmp++;
        if (d_out !== ex.v) begin n_bad++; $display("FAIL reset_rd%0h got %h want %h", ex.a, d_out, ex.v); end
        rd_cycle(4'h3, 16'h0000);
        ex = sb.pop_front(); n_cmp++;
        if (d_out !== ex.v) begin n_bad++; $display("FAIL reset_rd%0h got %h want %h", ex.a, d_out, ex.v); end
    endtask

    task automatic test_rw;
        logic [3:0]  ta[10] = '{4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hC, 4'hE, 4'h1, 4'hD, 4'hF};
        logic [15:0] tv[10] = '{16'd24, 16'd15, 16'd11, 16'd10, 16'd10, 16'd16, 16'd15, 16'd10, 16'd0, 16'd0};
        for (int i = 0; i < 8; i++) wr_cycle(ta[i], tv[i]);
        for (int i = 0; i < 10; i++) begin
            rd_cycle(ta[i], tv[i]);
            ex = sb.pop_front(); n_cmp++;
            if (d_out !== ex.v) begin n_bad++; $display("FAIL rw_rd%0h got %h want %h", ex.a, d_out, ex.v); end
        end
    endtask

    task automatic test_run;
        logic [3:0]  ta[5] = '{4'h3, 4'h5, 4'h7, 4'h9, 4'hB};
        logic [15:0] tv[5] = '{16'h0061, 16'd9, 16'd1, 16'd6, 16'd5};
        wr_cycle(4'h0, 16'h0001);
        for (int k = 0; k < 8; k++) begin
            rd_cycle(4'h0, (k < 6) ? 16'h0001 : 16'h0002);
            ex = sb.pop_front(); n_cmp++;
            if (d_out !== ex.v) begin n_bad++; $display("FAIL run_status%0d got %h want %h", k, d_out, ex.v); end
        end
        for (int i = 0; i < 5; i++) begin
            rd_cycle(ta[i], tv[i]);
            ex = sb.pop_front(); n_cmp++;
            if (d_out !== ex.v) begin n_bad++; $display("FAIL run_rd%0h got %h want %h", ex.a, d_out, ex.v); end
        end
    endtask

    task automatic test_snapshot;
        wr_cycle(4'h0, 16'h0001);
        wr_cycle(4'h4, 16'd30);
        wr_cycle(4'h0, 16'h0001);
        for (int k = 0; k < 8; k++) begin
            rd_cycle(4'h0, (k < 4) ? 16'h0001 : 16'h0002);
            ex = sb.pop_front(); n_cmp++;
            if (d_out !== ex.v) begin n_bad++; $display("FAIL snap_status%0d got %h want %h", k, d_out, ex.v); end
        end
        rd_cycle(4'h3, 16'h0061);
        ex = sb.pop_front(); n_cmp++;
        if (d_out !== ex.v) begin n_bad++; $display("FAIL snap_cmd got %h want %h", d_out, ex.v); end
        rd_cycle(4'h5, 16'd9);
        ex = sb.pop_front(); n_cmp++;
        if (d_out !== ex.v) begin n_bad++; $display("FAIL snap_magv got %h want %h", d_out, ex.v); end
        wr_cycle(4'h0, 16'h0001);
        idle(8);
        rd_cycle(4'h3, 16'h0062);
        ex = sb.pop_front(); n_cmp++;
        if (d_out !== ex.v) begin n_bad++; $display("FAIL rerun_cmd got %h want %h", d_out, ex.v); end
        rd_cycle(4'h5, 16'd6);
        ex = sb.pop_front(); n_cmp++;
        if (d_out !== ex.v) begin n_bad++; $display("FAIL rerun_magv got %h want %h", d_out, ex.v); end
    endtask

    task automatic test_boundary;
        logic [15:0] a_v[6] = '{16'hFFFF, 16'd100, 16'd102, 16'd103, 16'd100, 16'd100};
        logic [15:0] b_v[6] = '{16'h0000, 16'd100, 16'd100, 16'd100, 16'd102, 16'd103};
        logic [15:0] c_v[6] = '{16'h0061, 16'h0060, 16'h0060, 16'h0061, 16'h0060, 16'h0062};
        logic [15:0] m_v[6] = '{16'hFFFF, 16'd0, 16'd2, 16'd3, 16'd2, 16'd3};
        for (int i = 0; i < 6; i++) begin
            wr_cycle(4'h2, a_v[i]);
            wr_cycle(4'h4, b_v[i]);
            wr_cycle(4'h0, 16'h0001);
            idle(8);
            rd_cycle(4'h3, c_v[i]);
            ex = sb.pop_front(); n_cmp++;
            if (d_out !== ex.v) begin n_bad++; $display("FAIL bnd%0d_cmd got %h want %h", i, d_out, ex.v); end
            rd_cycle(4'h5, m_v[i]);
            ex = sb.pop_front(); n_cmp++;
            if (d_out !== ex.v) begin n_bad++; $display("FAIL bnd%0d_magv got %h want %h", i, d_out, ex.v); end
        end
        wr_cycle(4'h3, 16'hFFFF);
        wr_cycle(4'hF, 16'h1234);
        wr_cycle(4'hD, 16'h4321);
        wr_cycle(4'h0, 16'hFFFE);
        rd_cycle(4'h3, 16'h0062);
        ex = sb.pop_front(); n_cmp++;
        if (d_out !== ex.v) begin n_bad++; $display("FAIL ro_cmd got %h want %h", d_out, ex.v); end
        rd_cycle(4'hF, 16'h0000);
        ex = sb.pop_front(); n_cmp++;
        if (d_out !== ex.v) begin n_bad++; $display("FAIL rsvd_f got %h want %h", d_out, ex.v); end
        rd_cycle(4'hD, 16'h0000);
        ex = sb.pop_front(); n_cmp++;
        if (d_out !== ex.v) begin n_bad++; $display("FAIL rsvd_d got %h want %h", d_out, ex.v); end
        rd_cycle(4'h0, 16'h0002);
        ex = sb.pop_front(); n_cmp++;
        if (d_out !== ex.v) begin n_bad++; $display("FAIL ctrl_nostart got %h want %h", d_out, ex.v); end
    endtask

    task automatic test_rw_collision;
        exp_t t;
        t.a = 4'h2; t.v = 16'd100;
        sb.push_back(t);
        cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 4'h2; d_in = 16'h55AA;
        @(posedge clk); #1;
        cs = 1'b0; rd = 1'b0; wr = 1'b0; d_in = '0;
        ex = sb.pop_front(); n_cmp++;
        if (d_out !== ex.v) begin n_bad++; $display("FAIL coll_old got %h want %h", d_out, ex.v); end
        rd_cycle(4'h2, 16'h55AA);
        ex = sb.pop_front(); n_cmp++;
        if (d_out !== ex.v) begin n_bad++; $display("FAIL coll_new got %h want %h", d_out, ex.v); end
    endtask

    task automatic test_reset_midrun;
        logic [3:0] ta[6] = '{4'h0, 4'h3, 4'h5, 4'h2, 4'hC, 4'h9};
        wr_cycle(4'h0, 16'h0001);
        rd_cycle(4'h2, 16'h55AA);
        ex = sb.pop_front(); n_cmp++;
        if (d_out !== ex.v) begin n_bad++; $display("FAIL mid_rd1 got %h want %h", d_out, ex.v); end
        rd_cycle(4'h2, 16'h55AA);
        ex = sb.pop_front(); n_cmp++;
        if (d_out !== ex.v) begin n_bad++; $display("FAIL mid_rd2 got %h want %h", d_out, ex.v); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (d_out !== 16'h0000) begin n_bad++; $display("FAIL mid_async_dout got %h want %h", d_out, 16'h0000); end
        idle(2);
        rst = 1'b0;
        idle(1);
        for (int i = 0; i < 6; i++) begin
            rd_cycle(ta[i], 16'h0000);
            ex = sb.pop_front(); n_cmp++;
            if (d_out !== ex.v) begin n_bad++; $display("FAIL mid_rd%0h got %h want %h", ex.a, d_out, ex.v); end
        end
        idle(8);
        rd_cycle(4'h0, 16'h0000);
        ex = sb.pop_front(); n_cmp++;
        if (d_out !== ex.v) begin n_bad++; $display("FAIL mid_norun got %h want %h", d_out, ex.v); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rw();
        test_run();
        test_snapshot();
        test_boundary();
        test_rw_collision();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
